// File: rtl/peak_search_reader_pkg.sv
// Shared types and compare helpers for the
// ping-pong RAM B-port reader family.
package peak_search_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_GUARD = 3'd4
  } state_t;

  localparam int CMP_W = 65;

  typedef logic signed [CMP_W-1:0] cmp_t;

  // Widen a w-bit sample so one signed compare covers both modes.
  function automatic cmp_t widen(
    input logic [63:0] v,
    input int unsigned w,
    input logic        sgn
  );
    cmp_t r;
    logic neg;
    neg = sgn && v[6'(w - 1)];
    r = {1'b0, v};
    for (int i = 0; i < CMP_W; i++)
      if (neg && i >= int'(w)) r[i] = 1'b1;
    return r;
  endfunction

  // Strict better-than: greater in max mode, smaller in min mode.
  function automatic logic better(
    input logic [63:0] x,
    input logic [63:0] y,
    input int unsigned w,
    input logic        sgn,
    input logic        find_min
  );
    cmp_t xe;
    cmp_t ye;
    xe = widen(x, w, sgn);
    ye = widen(y, w, sgn);
    return find_min ? (xe < ye) : (xe > ye);
  endfunction

endpackage

// File: rtl/peak_search_reader_tracker.sv
// Best / second-best tracker with addresses.
// Results include the sample presented this cycle.
module peak_tracker
  import peak_search_reader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              find_min,
  output logic [DATA_W-1:0] best_data,
  output logic [ADDR_W-1:0] best_addr,
  output logic [DATA_W-1:0] second_data,
  output logic [ADDR_W-1:0] second_addr
);

  logic              hb_q, hs_q;
  logic [DATA_W-1:0] bd_q, sd_q;
  logic [ADDR_W-1:0] ba_q, sa_q;

  logic              hb_n, hs_n;
  logic [DATA_W-1:0] bd_n, sd_n;
  logic [ADDR_W-1:0] ba_n, sa_n;

  logic beats_best, beats_sec;

  assign beats_best = better(64'(data), 64'(bd_q),
                             DATA_W, SIGNED, find_min);
  assign beats_sec  = better(64'(data), 64'(sd_q),
                             DATA_W, SIGNED, find_min);

  // Update rule: new best demotes old best; else maybe fill second.
  always_comb begin
    hb_n = hb_q;
    hs_n = hs_q;
    bd_n = bd_q;
    ba_n = ba_q;
    sd_n = sd_q;
    sa_n = sa_q;
    if (valid) begin
      if (!hb_q) begin
        hb_n = 1'b1;
        bd_n = data;
        ba_n = addr;
      end else if (beats_best) begin
        hs_n = 1'b1;
        sd_n = bd_q;
        sa_n = ba_q;
        bd_n = data;
        ba_n = addr;
      end else if (!hs_q || beats_sec) begin
        hs_n = 1'b1;
        sd_n = data;
        sa_n = addr;
      end
    end
  end

  // Tracker registers, emptied at scan start.
  always_ff @(posedge clk_in) begin
    if (rst || clear) begin
      hb_q <= 1'b0;
      hs_q <= 1'b0;
      bd_q <= '0;
      ba_q <= '0;
      sd_q <= '0;
      sa_q <= '0;
    end else begin
      hb_q <= hb_n;
      hs_q <= hs_n;
      bd_q <= bd_n;
      ba_q <= ba_n;
      sd_q <= sd_n;
      sa_q <= sa_n;
    end
  end

  assign best_data   = bd_n;
  assign best_addr   = ba_n;
  assign second_data = sd_n;
  assign second_addr = sa_n;

endmodule

// File: rtl/peak_search_reader.sv
// Ping-pong RAM B-port reader: scans a bank and
// reports best and second-best samples.
module peak_search_reader
  import peak_search_reader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              readyb,
  input  logic [DATA_W-1:0] dout,
  input  logic              find_min,
  input  logic [DATA_W-1:0] threshold,
  output logic [ADDR_W-1:0] addr,
  output logic              finishb,
  output logic              busy,
  output logic [DATA_W-1:0] best_data,
  output logic [ADDR_W-1:0] best_addr,
  output logic [DATA_W-1:0] second_data,
  output logic [ADDR_W-1:0] second_addr,
  output logic              result_valid,
  output logic              no_peak_flag
);

  localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

  state_t            state;
  logic [1:0]        drain_cnt;
  logic              mode_q;
  logic [DATA_W-1:0] thr_q;

  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] vaddr_q [RD_LAT];

  logic              clear;
  logic [DATA_W-1:0] trk_bd, trk_sd;
  logic [ADDR_W-1:0] trk_ba, trk_sa;

  assign clear = (state == S_IDLE) && readyb;

  // Mark which dout cycles carry scan data and their address.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++)
        vaddr_q[i] <= '0;
    end else begin
      vld_q[0]   <= (state == S_READ);
      vaddr_q[0] <= addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]   <= vld_q[i-1];
        vaddr_q[i] <= vaddr_q[i-1];
      end
    end
  end

  peak_tracker #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .SIGNED (SIGNED)
  ) u_trk (
    .clk_in      (clk_in),
    .rst         (rst),
    .clear       (clear),
    .valid       (vld_q[RD_LAT-1]),
    .data        (dout),
    .addr        (vaddr_q[RD_LAT-1]),
    .find_min    (mode_q),
    .best_data   (trk_bd),
    .best_addr   (trk_ba),
    .second_data (trk_sd),
    .second_addr (trk_sa)
  );

  // Scan FSM with registered outputs; results load on entry to DONE.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state        <= S_IDLE;
      addr         <= '0;
      drain_cnt    <= '0;
      mode_q       <= 1'b0;
      thr_q        <= '0;
      busy         <= 1'b0;
      finishb      <= 1'b0;
      result_valid <= 1'b0;
      no_peak_flag <= 1'b0;
      best_data    <= '0;
      best_addr    <= '0;
      second_data  <= '0;
      second_addr  <= '0;
    end else begin
      finishb      <= 1'b0;
      result_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (readyb) begin
            state  <= S_READ;
            addr   <= '0;
            mode_q <= find_min;
            thr_q  <= threshold;
            busy   <= 1'b1;
          end
        end
        S_READ: begin
          if (addr == '1) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state        <= S_DONE;
            best_data    <= trk_bd;
            best_addr    <= trk_ba;
            second_data  <= trk_sd;
            second_addr  <= trk_sa;
            no_peak_flag <= !better(64'(trk_bd), 64'(thr_q),
                                    DATA_W, SIGNED, mode_q);
            result_valid <= 1'b1;
            finishb      <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_GUARD;
          busy  <= 1'b0;
        end
        S_GUARD: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
